axis_frame_compare: RTL and testbench
=====================================

# axis_frame_compare

Synthesizable AXI4-Stream checker that sits directly downstream of the bicubic upscaler. It consumes the DUT output stream and a golden reference stream beat-for-beat and compares each RGB channel against an absolute error threshold. It also checks frame framing (tuser/tlast) and reports per-frame mismatch statistics. It is the hardware counterpart of the bench-side relative-error compare, and is usable on FPGA without a file-reading testbench.

## Interface
- IMG_W, 128: output frame width in pixels (≥2)
- IMG_H, 128: output frame height in lines (≥2)
- CH_W, 8: bits per colour channel; tdata = {R,G,B}, 3*CH_W wide
- THRESH, 2: a channel mismatches when |dut−ref| > THRESH (LSBs)
- CNT_W, 24: width of mismatch counter
- clk  in  1  single clock
- rstn  in  1  asynchronous active-low reset
- s_dut_tdata/tvalid/tuser/tlast  in  3*CH_W/1/1/1  upscaler output; tuser = start of frame, tlast = end of line
- s_dut_tready  out  1
- s_ref_tdata/tvalid/tuser/tlast  in  3*CH_W/1/1/1  golden stream, same format
- s_ref_tready  out  1
- frame_done  out  1  one-cycle pulse: statistics below are valid
- mismatch_cnt  out  CNT_W  pixels with ≥1 mismatching channel this frame (saturating)
- max_err  out  CH_W  largest channel |dut−ref| this frame
- first_err_x, first_err_y  out  16/16  coordinates of first mismatching pixel (all-ones if none)
- framing_err  out  3  [0] tlast misplaced, [1] tuser misplaced, [2] dut/ref tuser or tlast disagree; sticky until next frame start

## Operation
- Join: a beat transfers only when both tvalids are high and state ≠ DONE. Both treadys = s_dut_tvalid & s_ref_tvalid & (state ≠ DONE). A lone valid is never consumed.
- FSM IDLE → RUN → DONE → IDLE.
  - IDLE: joined beats without tuser on both streams are consumed and discarded. A joined beat with tuser on either stream enters RUN at x=0, y=0. That beat is compared.
  - RUN: x increments per beat. On x = IMG_W−1, x wraps to 0 and y increments. The beat at x=IMG_W−1, y=IMG_H−1 moves to DONE.
  - DONE: one cycle, no transfer, then IDLE.
- Framing checks, on each compared beat:
  - tlast expected iff x = IMG_W−1; otherwise set [0].
  - tuser at (x,y) ≠ (0,0) sets [1]; the counters restart with this beat as pixel (0,0). Statistics from the aborted frame are discarded and no frame_done is produced for it.
  - dut.tuser ≠ ref.tuser or dut.tlast ≠ ref.tlast sets [2].
- Arithmetic:
  - Per channel, abs diff is CH_W bits, computed on a zero-extended CH_W+1 signed difference.
  - A pixel mismatches if any channel diff > THRESH.
  - max_err = max over all channels and pixels.
  - mismatch_cnt saturates at 2^CNT_W−1.
  - first_err_x/y latch only on the first mismatch of the frame.
- Statistics accumulators clear on the frame-start beat, before that beat is accumulated.

## Timing
- Reset values:
  - state = IDLE; x, y = 0.
  - treadys = 0; frame_done = 0.
  - mismatch_cnt = 0; max_err = 0; first_err_x/y = all-ones; framing_err = 0.
- Pipeline:
  - Stage 1 registers the channel diffs and beat coordinates.
  - Stage 2 updates the accumulators.
  - frame_done pulses 2 cycles after the handshake of the last pixel.
- Outputs hold their values from frame_done until the next frame-start beat reaches stage 2.
- Back-to-back frames are allowed. The DONE bubble is one cycle, so the next tuser beat can transfer 2 cycles after the last pixel.
- Reset mid-frame: all state returns to reset values immediately. The pipeline is flushed and no frame_done is produced.

## Structure
- Shared package `upscaler_pkg` holds:
  - the `rgb_t` packed struct {r,g,b} of CH_W each;
  - the `cmp_state_e` enum {IDLE, RUN, DONE};
  - the framing_err bit-index constants.
- One sub-module: `abs_diff_rgb`, which is combinational. It takes two rgb_t and THRESH, and outputs three diffs, a per-pixel mismatch flag and the max channel diff. It is instantiated in stage 1.

## Test plan
- Identical 4×2 frame on both streams, IMG_W=4, IMG_H=2 → frame_done once; mismatch_cnt=0, max_err=0, first_err=(FFFF,FFFF), framing_err=0.
- Ref pixel (2,1) G=0x80, DUT G=0x83, THRESH=2 → mismatch_cnt=1, max_err=3, first_err=(2,1). With DUT G=0x82 instead → mismatch_cnt=0, max_err=2.
- Random tvalid gaps, independent on each stream (dut valid held 5 cycles while ref low) → no beat consumed until both are valid; results match the gap-free run.
- tlast asserted on DUT at x=1 → framing_err=3'b101 at frame_done.
- tuser mid-frame at (1,1) → framing_err[1]=1, the frame restarts there, and only one frame_done follows, IMG_W*IMG_H beats later.
- rstn pulled low on beat 5 of a frame, then a clean frame is sent → only one frame_done, from the clean frame, with zero statistics.

Source files
------------

// File: rtl/upscaler_pkg.sv
// Shared types and constants for the upscaler output checker.
// Pixel channel width is fixed here; the checker's CH_W must match RGB_CH_W.
package upscaler_pkg;

  localparam int RGB_CH_W = 8;

  typedef struct packed {
    logic [RGB_CH_W-1:0] r;
    logic [RGB_CH_W-1:0] g;
    logic [RGB_CH_W-1:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_e;

  localparam int FE_TLAST    = 0;
  localparam int FE_TUSER    = 1;
  localparam int FE_DISAGREE = 2;

  // |a-b| taken from a zero-extended signed difference one bit wider than a channel
  function automatic logic [RGB_CH_W-1:0] abs_diff(input logic [RGB_CH_W-1:0] a,
                                                   input logic [RGB_CH_W-1:0] b);
    logic [RGB_CH_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[RGB_CH_W] ? RGB_CH_W'(-d) : d[RGB_CH_W-1:0];
  endfunction

endpackage

// File: rtl/axis_frame_compare_if.sv
// AXI4-Stream video beat bundle (tuser = start of frame, tlast = end of line).
interface axis_frame_compare_if #(
  parameter int DATA_W = 24
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tuser;
  logic              tlast;
  logic              tready;

  modport master (output tdata, output tvalid, output tuser, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tuser, input  tlast, output tready);
endinterface

// File: rtl/abs_diff_rgb.sv
// Combinational per-channel absolute difference between two pixels, with the
// largest channel difference and a threshold mismatch flag.
module abs_diff_rgb
  import upscaler_pkg::*;
#(
  parameter int THRESH = 2
) (
  input  rgb_t                a,
  input  rgb_t                b,
  output rgb_t                diff,
  output logic                mismatch,
  output logic [RGB_CH_W-1:0] max_diff
);

  localparam logic [RGB_CH_W-1:0] TH = RGB_CH_W'(THRESH);

  // Channel diffs, their maximum, and the threshold test on that maximum
  always_comb begin
    diff.r   = abs_diff(a.r, b.r);
    diff.g   = abs_diff(a.g, b.g);
    diff.b   = abs_diff(a.b, b.b);
    max_diff = diff.r;
    if (diff.g > max_diff) begin
      max_diff = diff.g;
    end else begin
      max_diff = max_diff;
    end
    if (diff.b > max_diff) begin
      max_diff = diff.b;
    end else begin
      max_diff = max_diff;
    end
    mismatch = (max_diff > TH);
  end

endmodule

// File: rtl/axis_frame_compare.sv
// Beat-for-beat comparator of the upscaler output against a golden stream:
// joined handshake, frame position FSM, 2-stage diff/accumulate pipeline.
module axis_frame_compare
  import upscaler_pkg::*;
#(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int CH_W   = RGB_CH_W,
  parameter int THRESH = 2,
  parameter int CNT_W  = 24
) (
  input  logic                 clk,
  input  logic                 rstn,
  axis_frame_compare_if.slave  s_dut,
  axis_frame_compare_if.slave  s_ref,
  output logic                 frame_done,
  output logic [CNT_W-1:0]     mismatch_cnt,
  output logic [CH_W-1:0]      max_err,
  output logic [15:0]          first_err_x,
  output logic [15:0]          first_err_y,
  output logic [2:0]           framing_err
);

  localparam logic [15:0]      X_LAST  = 16'(IMG_W - 1);
  localparam logic [15:0]      Y_LAST  = 16'(IMG_H - 1);
  localparam logic [15:0]      NO_ERR  = 16'hFFFF;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  cmp_state_e state_q, state_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic        hs_s, sof_s, tlast_any_s, disagree_s;
  rgb_t        dut_px_s, ref_px_s, diff_unused_s;

  logic              s1_v_d, s1_v_q, s1_start_d, s1_start_q, s1_clr_d, s1_clr_q;
  logic              s1_last_d, s1_last_q, s1_mm_d, s1_mm_q;
  logic [2:0]        s1_fe_d, s1_fe_q;
  logic [15:0]       s1_x_d, s1_x_q, s1_y_d, s1_y_q;
  logic [CH_W-1:0]   s1_max_d, s1_max_q;

  logic              frame_done_d, frame_done_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q, cnt_base_s;
  logic [CH_W-1:0]   max_err_d, max_err_q, max_base_s;
  logic [15:0]       fx_d, fx_q, fy_d, fy_q, fx_base_s, fy_base_s;
  logic [2:0]        fe_d, fe_q, fe_base_s;

  assign hs_s        = s_dut.tvalid & s_ref.tvalid & (state_q != DONE);
  assign s_dut.tready = hs_s;
  assign s_ref.tready = hs_s;
  assign sof_s       = s_dut.tuser | s_ref.tuser;
  assign tlast_any_s = s_dut.tlast | s_ref.tlast;
  assign disagree_s  = (s_dut.tuser != s_ref.tuser) | (s_dut.tlast != s_ref.tlast);
  assign dut_px_s    = rgb_t'(s_dut.tdata);
  assign ref_px_s    = rgb_t'(s_ref.tdata);

  abs_diff_rgb #(.THRESH(THRESH)) u_abs_diff (
    .a        (dut_px_s),
    .b        (ref_px_s),
    .diff     (diff_unused_s),
    .mismatch (s1_mm_d),
    .max_diff (s1_max_d)
  );

  // Frame position FSM; x_q/y_q hold the coordinates the next beat should have
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    s1_v_d     = 1'b0;
    s1_start_d = 1'b0;
    s1_clr_d   = 1'b0;
    s1_last_d  = 1'b0;
    s1_fe_d    = 3'b000;
    s1_x_d     = 16'd0;
    s1_y_d     = 16'd0;
    case (state_q)
      IDLE: begin
        if (hs_s && sof_s) begin
          s1_v_d     = 1'b1;
          s1_start_d = 1'b1;
          s1_clr_d   = 1'b1;
          x_d        = 16'd1;
          y_d        = 16'd0;
          state_d    = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (hs_s && sof_s) begin
          // Misplaced start of frame: restart counting with this beat as (0,0)
          s1_v_d            = 1'b1;
          s1_start_d        = 1'b1;
          s1_fe_d[FE_TUSER] = 1'b1;
          x_d               = 16'd1;
          y_d               = 16'd0;
        end else if (hs_s) begin
          s1_v_d = 1'b1;
          s1_x_d = x_q;
          s1_y_d = y_q;
          if (x_q == X_LAST) begin
            x_d = 16'd0;
            if (y_q == Y_LAST) begin
              y_d       = 16'd0;
              s1_last_d = 1'b1;
              state_d   = DONE;
            end else begin
              y_d = y_q + 16'd1;
            end
          end else begin
            x_d = x_q + 16'd1;
          end
        end else begin
          state_d = RUN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    s1_fe_d[FE_TLAST]    = s1_v_d & (tlast_any_s != (s1_x_d == X_LAST));
    s1_fe_d[FE_DISAGREE] = s1_v_d & disagree_s;
  end

  // State and position registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      x_q     <= 16'd0;
      y_q     <= 16'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Stage 1: compared beat's diff summary, coordinates and framing flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_v_q     <= 1'b0;
      s1_start_q <= 1'b0;
      s1_clr_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_fe_q    <= 3'b000;
      s1_x_q     <= 16'd0;
      s1_y_q     <= 16'd0;
      s1_mm_q    <= 1'b0;
      s1_max_q   <= '0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_start_q <= s1_start_d;
      s1_clr_q   <= s1_clr_d;
      s1_last_q  <= s1_last_d;
      s1_fe_q    <= s1_fe_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s1_mm_q    <= s1_mm_d;
      s1_max_q   <= s1_max_d;
    end
  end

  // Stage 2: accumulators, cleared by a frame-start beat before it is added
  always_comb begin
    frame_done_d = 1'b0;
    cnt_d        = cnt_q;
    max_err_d    = max_err_q;
    fx_d         = fx_q;
    fy_d         = fy_q;
    fe_d         = fe_q;
    cnt_base_s   = s1_start_q ? '0 : cnt_q;
    max_base_s   = s1_start_q ? '0 : max_err_q;
    fx_base_s    = s1_start_q ? NO_ERR : fx_q;
    fy_base_s    = s1_start_q ? NO_ERR : fy_q;
    fe_base_s    = s1_clr_q ? 3'b000 : fe_q;
    if (s1_v_q) begin
      frame_done_d = s1_last_q;
      cnt_d        = (s1_mm_q && (cnt_base_s != CNT_MAX)) ? cnt_base_s + CNT_W'(1) : cnt_base_s;
      max_err_d    = (s1_max_q > max_base_s) ? s1_max_q : max_base_s;
      fe_d         = fe_base_s | s1_fe_q;
      if (s1_mm_q && (fx_base_s == NO_ERR)) begin
        fx_d = s1_x_q;
        fy_d = s1_y_q;
      end else begin
        fx_d = fx_base_s;
        fy_d = fy_base_s;
      end
    end else begin
      frame_done_d = 1'b0;
    end
  end

  // Statistics registers, driven straight to the outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_done_q <= 1'b0;
      cnt_q        <= '0;
      max_err_q    <= '0;
      fx_q         <= NO_ERR;
      fy_q         <= NO_ERR;
      fe_q         <= 3'b000;
    end else begin
      frame_done_q <= frame_done_d;
      cnt_q        <= cnt_d;
      max_err_q    <= max_err_d;
      fx_q         <= fx_d;
      fy_q         <= fy_d;
      fe_q         <= fe_d;
    end
  end

  assign frame_done   = frame_done_q;
  assign mismatch_cnt = cnt_q;
  assign max_err      = max_err_q;
  assign first_err_x  = fx_q;
  assign first_err_y  = fy_q;
  assign framing_err  = fe_q;

endmodule

// File: tb/tb_axis_frame_compare.sv
// Directed bench for axis_frame_compare on a 4x2 frame with THRESH=2.
module tb_axis_frame_compare;

  logic        clk;
  logic        rstn;
  logic        frame_done;
  logic [23:0] mismatch_cnt;
  logic [7:0]  max_err;
  logic [15:0] first_err_x, first_err_y;
  logic [2:0]  framing_err;
  int          total;
  int          bad;
  int          fd_count;
  int          fd_snap;

  axis_frame_compare_if dut_if ();
  axis_frame_compare_if ref_if ();

  axis_frame_compare #(
    .IMG_W(4), .IMG_H(2), .CH_W(8), .THRESH(2), .CNT_W(24)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .s_dut        (dut_if),
    .s_ref        (ref_if),
    .frame_done   (frame_done),
    .mismatch_cnt (mismatch_cnt),
    .max_err      (max_err),
    .first_err_x  (first_err_x),
    .first_err_y  (first_err_y),
    .framing_err  (framing_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_count++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int x, input int y);
    logic [7:0] r, g, b;
    r = 8'(32 + x * 8 + y);
    g = 8'(64 + x + y * 4);
    b = 8'(160 - x - y);
    return {r, g, b};
  endfunction

  // lead_sel: 0 both valid together, 1 dut valid alone first, 2 ref valid alone first
  task automatic xfer(input logic [23:0] dd, input logic [23:0] rd, input logic du, input logic ru,
                      input logic dl, input logic rl, input int lead_sel, input int lead_cyc);
    int   n;
    logic stuck;
    @(negedge clk);
    dut_if.tdata = dd; dut_if.tuser = du; dut_if.tlast = dl;
    ref_if.tdata = rd; ref_if.tuser = ru; ref_if.tlast = rl;
    dut_if.tvalid = (lead_sel != 2);
    ref_if.tvalid = (lead_sel != 1);
    if (lead_sel != 0) begin
      stuck = 1'b0;
      for (int i = 0; i < lead_cyc; i++) begin
        #1;
        if (dut_if.tready !== 1'b0 || ref_if.tready !== 1'b0) stuck = 1'b1;
        @(negedge clk);
      end
      chk("lone_valid_ready", {31'd0, stuck}, 32'd0);
      dut_if.tvalid = 1'b1;
      ref_if.tvalid = 1'b1;
    end
    #1;
    n = 0;
    while (dut_if.tready !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("handshake_timeout", {31'd0, dut_if.tready}, 32'd1);
    @(posedge clk);
  endtask

  // mode: 0 identical, 1 G off by 3 at (2,1), 2 G off by 2 at (2,1), 3 dut tlast at x=1, 4 as 1 with valid gaps
  task automatic beat_idx(input int k, input int mode);
    int x, y, lsel, lcyc;
    logic [23:0] dd, rd;
    logic tu, tl, dl;
    x = k % 4;
    y = k / 4;
    rd = pix(x, y);
    dd = rd;
    if ((mode == 1 || mode == 2 || mode == 4) && x == 2 && y == 1) begin
      rd[15:8] = 8'h80;
      dd[15:8] = (mode == 2) ? 8'h82 : 8'h83;
    end
    tu = (k == 0);
    tl = (x == 3);
    dl = tl | ((mode == 3) && (k == 1));
    lsel = 0;
    lcyc = 0;
    if (mode == 4 && k == 0) begin lsel = 1; lcyc = 5; end
    if (mode == 4 && k == 5) begin lsel = 2; lcyc = 3; end
    xfer(dd, rd, tu, tu, dl, tl, lsel, lcyc);
  endtask

  task automatic end_frame();
    @(negedge clk);
    dut_if.tvalid = 1'b0; ref_if.tvalid = 1'b0;
    dut_if.tuser = 1'b0; ref_if.tuser = 1'b0;
    dut_if.tlast = 1'b0; ref_if.tlast = 1'b0;
    chk("fd_early", {31'd0, frame_done}, 32'd0);
    @(negedge clk);
    chk("fd_pulse", {31'd0, frame_done}, 32'd1);
    @(negedge clk);
    chk("fd_single", {31'd0, frame_done}, 32'd0);
  endtask

  task automatic send_frame(input int mode);
    for (int k = 0; k < 8; k++) beat_idx(k, mode);
    end_frame();
  endtask

  task automatic check_stats(input string p, input int mm, input int mx, input int fx,
                             input int fy, input int fe, input int fdc);
    chk($sformatf("%s_mismatch_cnt", p), {8'd0, mismatch_cnt}, mm);
    chk($sformatf("%s_max_err", p), {24'd0, max_err}, mx);
    chk($sformatf("%s_first_x", p), {16'd0, first_err_x}, fx);
    chk($sformatf("%s_first_y", p), {16'd0, first_err_y}, fy);
    chk($sformatf("%s_framing", p), {29'd0, framing_err}, fe);
    chk($sformatf("%s_fd_count", p), fd_count, fdc);
  endtask

  initial begin
    total = 0; bad = 0; fd_count = 0;
    rstn = 1'b0;
    dut_if.tdata = 24'd0; dut_if.tvalid = 1'b0; dut_if.tuser = 1'b0; dut_if.tlast = 1'b0;
    ref_if.tdata = 24'd0; ref_if.tvalid = 1'b0; ref_if.tuser = 1'b0; ref_if.tlast = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tready_dut", {31'd0, dut_if.tready}, 32'd0);
    chk("rst_tready_ref", {31'd0, ref_if.tready}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check_stats("rst", 0, 0, 16'hFFFF, 16'hFFFF, 0, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // A beat without tuser while idle is swallowed
    xfer(24'h123456, 24'h654321, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);

    send_frame(0);
    check_stats("identical", 0, 0, 16'hFFFF, 16'hFFFF, 0, 1);

    send_frame(1);
    check_stats("g_err3", 1, 3, 2, 1, 0, 2);

    send_frame(2);
    check_stats("g_err2", 0, 2, 16'hFFFF, 16'hFFFF, 0, 3);

    send_frame(4);
    check_stats("gaps", 1, 3, 2, 1, 0, 4);

    send_frame(3);
    check_stats("tlast_x1", 0, 0, 16'hFFFF, 16'hFFFF, 3'b101, 5);

    // Restart: tuser arrives at (1,1) and a full frame follows from there
    fd_snap = fd_count;
    for (int k = 0; k < 5; k++) beat_idx(k, 0);
    for (int k = 0; k < 8; k++) beat_idx(k, 0);
    end_frame();
    check_stats("restart", 0, 0, 16'hFFFF, 16'hFFFF, 3'b010, fd_snap + 1);

    // Reset on the fifth beat of a frame carrying a framing error
    for (int k = 0; k < 5; k++) beat_idx(k, 3);
    @(negedge clk);
    rstn = 1'b0;
    dut_if.tvalid = 1'b0; ref_if.tvalid = 1'b0;
    #1;
    check_stats("midrst", 0, 0, 16'hFFFF, 16'hFFFF, 0, 6);
    chk("midrst_frame_done", {31'd0, frame_done}, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_no_done", fd_count, 6);
    send_frame(0);
    check_stats("post_rst", 0, 0, 16'hFFFF, 16'hFFFF, 0, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
